// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: master FSM states, default widths and the
// request record that later multi-master arbiters pass around.
package wb_pkg;

   localparam int WB_DW = 32;
   localparam int WB_AW = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic             we;
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/wb_pipe_master_if.sv
// Bundle of the command port and the Wishbone pipelined bus seen by one
// master. Signal names keep the master's point of view (_i into the master,
// _o out of it) so the bench and the RTL read the same way.
interface wb_pipe_master_if
   import wb_pkg::*;
#(
   parameter int AW = 1,
   parameter int DW = WB_DW
) ();

   // command / response side
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_we_i;
   logic [AW-1:0] req_adr_i;
   logic [DW-1:0] req_dat_i;
   logic          rsp_valid_o;
   logic [DW-1:0] rsp_dat_o;
   logic          rsp_err_o;

   // Wishbone side
   logic          cyc_o;
   logic          stb_o;
   logic          we_o;
   logic [AW-1:0] adr_o;
   logic [DW-1:0] dat_o;
   logic [DW-1:0] dat_i;
   logic          ack_i;
   logic          stall_i;

   modport master (
      input  req_valid_i, req_we_i, req_adr_i, req_dat_i,
      input  dat_i, ack_i, stall_i,
      output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      output cyc_o, stb_o, we_o, adr_o, dat_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_adr_i, req_dat_i,
      output dat_i, ack_i, stall_i,
      input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  cyc_o, stb_o, we_o, adr_o, dat_o
   );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter used by bus masters to abort a cycle that the
// slave never acknowledges. Clear has priority over enable; expired_o is
// raised while the count sits in the last allowed cycle.
module wb_timeout_ctr #(
   parameter int TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Next count: clear wins, otherwise count up and stick at TIMEOUT
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != TW'(TIMEOUT))) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_pipe_master.sv
// Single-transaction Wishbone pipelined master. Each accepted command becomes
// one bus cycle: STB is held through slave stall, then the master waits for
// ACK or gives up after TIMEOUT cycles and reports an error instead.
module wb_pipe_master
   import wb_pkg::*;
#(
   parameter int AW      = 1,
   parameter int DW      = WB_DW,
   parameter int TIMEOUT = 64
) (
   input logic               clk_i,
   input logic               rst_ni,
   wb_pipe_master_if.master  bus
);

   wb_state_e     state_q;
   logic          cyc_q;
   logic          stb_q;
   logic          we_q;
   logic [AW-1:0] adr_q;
   logic [DW-1:0] dat_q;
   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic [DW-1:0] rsp_dat_q;
   logic          expired;

   // Timer restarts whenever the master is idle and runs for the whole cycle
   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (state_q == IDLE),
      .enable_i  (state_q != IDLE),
      .expired_o (expired)
   );

   // Transaction FSM with registered bus and response outputs; an ACK in
   // WAIT beats a simultaneous timeout, and ACKs outside WAIT are ignored
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid_i) begin
                  we_q    <= bus.req_we_i;
                  adr_q   <= bus.req_adr_i;
                  dat_q   <= bus.req_dat_i;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (expired) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  state_q     <= IDLE;
               end else if (!bus.stall_i) begin
                  stb_q   <= 1'b0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (bus.ack_i) begin
                  rsp_dat_q   <= bus.dat_i;
                  rsp_valid_q <= 1'b1;
                  cyc_q       <= 1'b0;
                  state_q     <= IDLE;
               end else if (expired) begin
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               cyc_q   <= 1'b0;
               stb_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_o = (state_q == IDLE);
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.rsp_dat_o   = rsp_dat_q;
   assign bus.cyc_o       = cyc_q;
   assign bus.stb_o       = stb_q;
   assign bus.we_o        = we_q;
   assign bus.adr_o       = adr_q;
   assign bus.dat_o       = dat_q;

endmodule

// File: doc/wb_pipe_master.md
# wb_pipe_master

Single-transaction Wishbone pipelined-mode bus master driving one of the team's Wishbone slaves (e.g. the LED sequencer peripheral) from a simple valid/ready command port. It converts each command into one Wishbone cycle, holds STB through slave stall, and waits for ACK. It returns read data or a timeout error on a one-cycle response strobe. It sits between a host/test controller and the slave bus.

## Interface
- AW, 1, address width (matches slave adr_i)
- DW, 32, data width
- TIMEOUT, 64, cycles from cycle start to abort if no ACK (≥2)
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  command present
- req_ready_o  out  1  command accepted when valid&&ready
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  AW  address
- req_dat_i  in  DW  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  DW  read data (dat_i captured on ACK)
- rsp_err_o  out  1  1 = timeout, valid with rsp_valid_o
- cyc_o, stb_o, we_o  out  1 each  Wishbone control
- adr_o  out  AW;  dat_o  out  DW  Wishbone address/write data
- dat_i  in  DW;  ack_i, stall_i  in  1 each  Wishbone slave response

## Operation
- FSM states IDLE, REQ, WAIT.
- IDLE: req_ready_o=1. On req_valid_i: latch we/adr/dat into adr_o/dat_o/we_o, clear timer, go REQ.
- REQ: cyc_o=stb_o=1, adr/dat/we stable. If !stall_i at clock edge: request accepted, go WAIT (stb_o drops next cycle).
- WAIT: cyc_o=1, stb_o=0. On ack_i: capture dat_i into rsp_dat_o, pulse rsp_valid_o with rsp_err_o=0, drop cyc_o, go IDLE.
- Timer increments every cycle in REQ and WAIT. Reaching TIMEOUT-1 without ACK drops cyc_o/stb_o, pulses rsp_valid_o with rsp_err_o=1, and goes IDLE. rsp_dat_o holds its previous value.
- ack_i in IDLE or REQ is spurious and ignored: no response, no state change.
- ACK and timeout in the same cycle: ACK wins, err=0.
- Writes: rsp_dat_o still captures dat_i on ACK; callers ignore it.
- Timer width $clog2(TIMEOUT+1), saturates and never wraps.

## Timing
- Reset (async assert, sync-release use): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, timer=0.
- All outputs registered, except req_ready_o, which is decoded from state.
- Command accepted at edge N: cyc_o/stb_o high from N+1.
- Slave not stalling: stb_o high exactly 1 cycle. ACK at N+2 gives rsp_valid_o at N+3. Minimum command-to-response latency is 3 cycles.
- Next command is accepted in the cycle rsp_valid_o is high (IDLE), giving back-to-back throughput of one transaction per 3 cycles.
- Reset asserted mid-cycle: cyc_o/stb_o drop immediately (async), no response is issued, and any late ACK after reset is ignored.

## Structure
- Shared package wb_pkg: state enum (IDLE/REQ/WAIT), the default DW constant, and a request struct (we, adr, dat) reused by future multi-master arbiters.
- Timeout counter is a natural sub-module: wb_timeout_ctr (clear, enable, TIMEOUT param, expired output), reused by later masters.

## Test plan
- Write 32'h0000_00A5 to adr 0; slave model acks 1 cycle after accept, no stall. Required: stb_o high 1 cycle, rsp_valid_o 3 cycles after accept, rsp_err_o=0.
- Read adr 1; slave returns dat_i=32'h0000_0007 with ACK. Required: rsp_dat_o=32'h7 and we_o=0 throughout.
- LED-sequencer slave model: write, then an immediate second write while the slave is busy (stall_i held 15 cycles). Required: second stb_o held with stable adr/dat until stall drops, then one ACK, no err.
- Slave never acks, TIMEOUT=64. Required: cyc_o drops and rsp_valid_o=1 with rsp_err_o=1 exactly 64 cycles after cyc_o rises; req_ready_o=1 next.
- Spurious ack_i pulse in IDLE, then rst_ni pulled low while in WAIT. Required: no rsp_valid_o, cyc_o=0 asynchronously, all outputs at reset values.
- Back-to-back 4 commands with req_valid_i held high. Required: 4 responses in order, 3 cycles apart, no command dropped.
